// File: rtl/serializer_stream.sv
// serializer_stream: parallel-to-serial stage, one N_SAMPLES-word frame in, words out lowest index first.
// Latency: first word valid the cycle after the frame is accepted; back-to-back frames stream with no bubble.
// Backpressure: send_rdy low freezes word/index/buffer; a new frame is taken only as the last word leaves.
//
// Ports:
//   clk, reset            - clock and synchronous active-high reset
//   recv_msg/val/rdy      - frame input, word i = recv_msg[BIT_WIDTH*i +: BIT_WIDTH]
//   send_msg/val/rdy      - word stream output
module serializer_stream #(
  parameter int BIT_WIDTH = 32,
  parameter int N_SAMPLES = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [BIT_WIDTH*N_SAMPLES-1:0] recv_msg,
  input  logic                           recv_val,
  output logic                           recv_rdy,
  output logic [BIT_WIDTH-1:0]           send_msg,
  output logic                           send_val,
  input  logic                           send_rdy
);

  localparam int IDX_W = $clog2(N_SAMPLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SAMPLES - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [BIT_WIDTH-1:0] buf_q [N_SAMPLES];
  logic                 load;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      for (int i = 0; i < N_SAMPLES; i++) buf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (load) begin
        for (int i = 0; i < N_SAMPLES; i++) buf_q[i] <= recv_msg[BIT_WIDTH*i +: BIT_WIDTH];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    load     = 1'b0;
    recv_rdy = 1'b0;
    send_val = 1'b0;
    send_msg = '0;
    case (state_q)
      IDLE: begin
        recv_rdy = 1'b1;
        if (recv_val) begin
          load    = 1'b1;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        send_val = 1'b1;
        send_msg = buf_q[idx_q];
        // Accept the next frame only in the cycle the last word leaves, so the
        // new word 0 follows immediately. Downstream must not loop recv_rdy
        // back into send_rdy.
        recv_rdy = (idx_q == LAST_IDX) && send_rdy;
        if (send_rdy) begin
          if (idx_q != LAST_IDX) begin
            idx_d = idx_q + 1'b1;
          end else begin
            idx_d = '0;
            if (recv_val) load = 1'b1;
            else          state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Handshakes are dead while reset is held; the registers clear on the edge.
    if (reset) begin
      recv_rdy = 1'b0;
      send_val = 1'b0;
      load     = 1'b0;
    end
  end

endmodule

// File: tb/tb_serializer_stream.sv
module tb_serializer_stream;
  localparam int BW = 32;
  localparam int NS = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [BW*NS-1:0] recv_msg;
  logic             recv_val;
  logic             recv_rdy;
  logic [BW-1:0]    send_msg;
  logic             send_val;
  logic             send_rdy;

  int checks = 0;
  int errors = 0;
  logic [BW-1:0] exp_q [$];

  serializer_stream #(.BIT_WIDTH(BW), .N_SAMPLES(NS)) dut (
    .clk(clk), .reset(reset),
    .recv_msg(recv_msg), .recv_val(recv_val), .recv_rdy(recv_rdy),
    .send_msg(send_msg), .send_val(send_val), .send_rdy(send_rdy)
  );

  always #5 clk = ~clk;

  function automatic logic [BW*NS-1:0] mk_frame(input logic [BW-1:0] base);
    logic [BW*NS-1:0] f;
    for (int i = 0; i < NS; i++) f[BW*i +: BW] = base + BW'(i);
    return f;
  endfunction

  task automatic push_frame(input logic [BW-1:0] base);
    for (int i = 0; i < NS; i++) exp_q.push_back(base + BW'(i));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every send transfer must match the head of the expected queue.
  always @(negedge clk) begin
    if (reset === 1'b0 && send_val === 1'b1 && send_rdy === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_unexpected got %0h with empty queue", send_msg);
      end else begin
        logic [BW-1:0] e;
        e = exp_q.pop_front();
        if (send_msg !== e) begin
          errors++;
          $display("FAIL scoreboard_word got %0h exp %0h", send_msg, e);
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1; recv_val = 1'b0; send_rdy = 1'b1; recv_msg = '0;
    next_cycle();
    @(negedge clk);
    checks++;
    if (recv_rdy !== 1'b0 || send_val !== 1'b0) begin
      errors++;
      $display("FAIL reset_gating got rdy=%b val=%b exp rdy=0 val=0", recv_rdy, send_val);
    end
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (recv_rdy !== 1'b1 || send_val !== 1'b0 || send_msg !== '0) begin
      errors++;
      $display("FAIL reset_idle got rdy=%b val=%b msg=%0h exp rdy=1 val=0 msg=0", recv_rdy, send_val, send_msg);
    end
    next_cycle();
  endtask

  task automatic check_queue_empty(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain got %0d words left exp 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_single();
    for (int cyc = 0; cyc <= 9; cyc++) begin
      if (cyc == 0) begin
        recv_msg = mk_frame(32'h100); recv_val = 1'b1; send_rdy = 1'b1; push_frame(32'h100);
      end else begin
        recv_val = 1'b0; recv_msg = mk_frame(32'hEEE0);
      end
      @(negedge clk);
      checks++;
      if (send_val !== (cyc >= 1 && cyc <= 8)) begin
        errors++;
        $display("FAIL single_val cyc %0d got %b exp %b", cyc, send_val, (cyc >= 1 && cyc <= 8));
      end
      if (cyc == 0 || cyc == 9) begin
        checks++;
        if (recv_rdy !== 1'b1) begin
          errors++;
          $display("FAIL single_rdy cyc %0d got %b exp 1", cyc, recv_rdy);
        end
      end
      next_cycle();
    end
    check_queue_empty("single");
  endtask

  task automatic test_back_to_back();
    int acc = 0;
    recv_msg = mk_frame(32'hA0); recv_val = 1'b1; send_rdy = 1'b1; push_frame(32'hA0);
    for (int cyc = 0; cyc <= 17; cyc++) begin
      @(negedge clk);
      checks++;
      if (send_val !== (cyc >= 1 && cyc <= 16)) begin
        errors++;
        $display("FAIL b2b_val cyc %0d got %b exp %b", cyc, send_val, (cyc >= 1 && cyc <= 16));
      end
      if (cyc <= 15) begin
        checks++;
        if (recv_rdy !== (cyc == 0 || cyc == 8)) begin
          errors++;
          $display("FAIL b2b_rdy cyc %0d got %b exp %b", cyc, recv_rdy, (cyc == 0 || cyc == 8));
        end
      end
      if (recv_val && recv_rdy) acc++;
      next_cycle();
      if (acc == 1 && recv_msg !== mk_frame(32'hB0)) begin
        recv_msg = mk_frame(32'hB0); push_frame(32'hB0);
      end else if (acc == 2) begin
        recv_val = 1'b0;
      end
    end
    check_queue_empty("b2b");
  endtask

  task automatic test_backpressure();
    int sent = 0;
    for (int cyc = 0; cyc <= 12; cyc++) begin
      if (cyc == 0) begin
        recv_msg = mk_frame(32'h100); recv_val = 1'b1; push_frame(32'h100);
      end else begin
        recv_val = 1'b0;
      end
      send_rdy = !(cyc == 2 || cyc == 3 || cyc == 5);
      @(negedge clk);
      if (cyc >= 1 && cyc <= 11) begin
        checks++;
        if (send_val !== 1'b1 || send_msg !== BW'(32'h100 + sent)) begin
          errors++;
          $display("FAIL bp_word cyc %0d got val=%b msg=%0h exp val=1 msg=%0h", cyc, send_val, send_msg, 32'h100 + sent);
        end
        if (send_rdy) sent++;
        if (cyc <= 10) begin
          checks++;
          if (recv_rdy !== 1'b0) begin
            errors++;
            $display("FAIL bp_rdy cyc %0d got %b exp 0", cyc, recv_rdy);
          end
        end
      end
      next_cycle();
    end
    send_rdy = 1'b1;
    checks++;
    if (sent != NS) begin
      errors++;
      $display("FAIL bp_count got %0d exp %0d", sent, NS);
    end
    check_queue_empty("bp");
  endtask

  task automatic test_last_stall();
    int acc = 0;
    for (int cyc = 0; cyc <= 19; cyc++) begin
      if (cyc == 0) begin
        recv_msg = mk_frame(32'h100); recv_val = 1'b1; push_frame(32'h100);
      end else if (cyc == 1) begin
        recv_msg = mk_frame(32'h300); recv_val = 1'b1; push_frame(32'h300);
      end else if (acc == 2) begin
        recv_val = 1'b0;
      end
      send_rdy = !(cyc == 8 || cyc == 9);
      @(negedge clk);
      if (recv_val && recv_rdy) acc++;
      if (cyc >= 1 && cyc <= 10) begin
        checks++;
        if (recv_rdy !== (cyc == 10)) begin
          errors++;
          $display("FAIL last_stall_rdy cyc %0d got %b exp %b", cyc, recv_rdy, (cyc == 10));
        end
      end
      if (cyc == 9 || cyc == 11) begin
        checks++;
        if (send_msg !== ((cyc == 9) ? 32'h107 : 32'h300)) begin
          errors++;
          $display("FAIL last_stall_msg cyc %0d got %0h exp %0h", cyc, send_msg, (cyc == 9) ? 32'h107 : 32'h300);
        end
      end
      next_cycle();
    end
    recv_val = 1'b0;
    check_queue_empty("last_stall");
  endtask

  task automatic test_reset_mid();
    for (int cyc = 0; cyc <= 15; cyc++) begin
      recv_val = 1'b0;
      if (cyc == 0) begin
        recv_msg = mk_frame(32'h100); recv_val = 1'b1; push_frame(32'h100);
      end
      if (cyc == 4) begin
        reset = 1'b1; exp_q.delete();
      end
      if (cyc == 5) begin
        reset = 1'b0; recv_msg = mk_frame(32'h200); recv_val = 1'b1; push_frame(32'h200);
      end
      @(negedge clk);
      if (cyc == 4) begin
        checks++;
        if (send_val !== 1'b0 || recv_rdy !== 1'b0) begin
          errors++;
          $display("FAIL rst_mid_gate got val=%b rdy=%b exp 0 0", send_val, recv_rdy);
        end
      end
      if (cyc == 5) begin
        checks++;
        if (send_val !== 1'b0 || recv_rdy !== 1'b1) begin
          errors++;
          $display("FAIL rst_mid_idle got val=%b rdy=%b exp val=0 rdy=1", send_val, recv_rdy);
        end
      end
      if (cyc == 6) begin
        checks++;
        if (send_val !== 1'b1 || send_msg !== 32'h200) begin
          errors++;
          $display("FAIL rst_mid_restart got val=%b msg=%0h exp val=1 msg=200", send_val, send_msg);
        end
      end
      next_cycle();
    end
    check_queue_empty("rst_mid");
  endtask

  task automatic test_busy_ignore();
    for (int cyc = 0; cyc <= 9; cyc++) begin
      recv_val = 1'b0;
      if (cyc == 0) begin
        recv_msg = mk_frame(32'h100); recv_val = 1'b1; push_frame(32'h100);
      end
      if (cyc == 3) begin
        recv_msg = mk_frame(32'hDEAD0); recv_val = 1'b1;
      end
      @(negedge clk);
      if (cyc == 3) begin
        checks++;
        if (recv_rdy !== 1'b0 || send_msg !== 32'h102) begin
          errors++;
          $display("FAIL busy_ignore got rdy=%b msg=%0h exp rdy=0 msg=102", recv_rdy, send_msg);
        end
      end
      if (cyc == 9) begin
        checks++;
        if (send_val !== 1'b0) begin
          errors++;
          $display("FAIL busy_end_val got %b exp 0", send_val);
        end
      end
      next_cycle();
    end
    check_queue_empty("busy");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_last_stall();
    test_reset_mid();
    test_busy_ignore();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
